// File: rtl/mips_pkg.sv
// Shared constants and small helpers for the MIPS pipeline front end.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  PC_INC        = 32'h0000_0004;
  localparam logic [ADDR_W-1:0]  RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEL_SEQ  = 2'd0,
    PC_SEL_HOLD = 2'd1,
    PC_SEL_ID   = 2'd2,
    PC_SEL_EX   = 2'd3
  } pc_sel_e;

  // Redirect targets are silently word-aligned rather than raising a fault.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or flush it to a NOP bubble.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_plus4_in,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               valid
);

  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [ADDR_W-1:0]  pc_plus4_d, pc_plus4_q;
  logic               valid_d, valid_q;

  // Flush beats load so a redirect always squashes the wrong-path word.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = 32'h0000_0000;
      valid_d    = 1'b0;
    end else if (load) begin
      instr_d    = instr_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end else begin
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc_plus4 = pc_plus4_q;
  assign valid    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, ROM addressing and IF/ID capture.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               id_redirect,
  input  logic [ADDR_W-1:0]  id_target,
  input  logic               ex_redirect,
  input  logic [ADDR_W-1:0]  ex_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus4,
  output logic               if_id_valid,
  output logic [31:0]        fetch_count
);

  pc_sel_e           pc_sel;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [ADDR_W-1:0] pc_plus4;
  logic [31:0]       fetch_count_d, fetch_count_q;
  logic              load_s, flush_s;

  assign pc_plus4 = pc_q + PC_INC;

  // EX redirect outranks ID redirect because the instruction in ID is itself wrong-path.
  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (ex_redirect) begin
      pc_sel = PC_SEL_EX;
    end else if (id_redirect) begin
      pc_sel = PC_SEL_ID;
    end else if (stall) begin
      pc_sel = PC_SEL_HOLD;
    end else begin
      pc_sel = PC_SEL_SEQ;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    load_s        = 1'b0;
    flush_s       = 1'b0;
    case (pc_sel)
      PC_SEL_EX: begin
        pc_d    = word_align(ex_target);
        flush_s = 1'b1;
      end
      PC_SEL_ID: begin
        pc_d    = word_align(id_target);
        flush_s = 1'b1;
      end
      PC_SEL_HOLD: begin
        pc_d = pc_q;
      end
      PC_SEL_SEQ: begin
        pc_d          = pc_plus4;
        fetch_count_d = fetch_count_q + 32'd1;
        load_s        = 1'b1;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load_s),
    .flush       (flush_s),
    .instr_in    (imem_rdata),
    .pc_plus4_in (pc_plus4),
    .instr       (if_id_instr),
    .pc_plus4    (if_id_pc_plus4),
    .valid       (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with a behavioural instruction ROM.
module tb_if_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        id_redirect;
  logic [31:0] id_target;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        stall;
    logic        id_r;
    logic [31:0] id_t;
    logic        ex_r;
    logic [31:0] ex_t;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {24'h8C_1000, a[9:2]};
  endfunction

  function automatic vec_t mk(input logic s, input logic ir, input logic [31:0] it,
                              input logic er, input logic [31:0] et,
                              input logic [31:0] epc, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep,
                              input logic [31:0] ec);
    vec_t v;
    v.stall = s; v.id_r = ir; v.id_t = it; v.ex_r = er; v.ex_t = et;
    v.e_pc = epc; v.e_valid = ev; v.e_instr = ei; v.e_pp4 = ep; v.e_cnt = ec;
    return v;
  endfunction

  assign imem_rdata = rom_word(imem_addr);

  if_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .id_redirect    (id_redirect),
    .id_target      (id_target),
    .ex_redirect    (ex_redirect),
    .ex_target      (ex_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_v,
                           input logic [31:0] e_i, input logic [31:0] e_p, input logic [31:0] e_c);
    check({tag, " pc"}, pc, e_pc);
    check({tag, " imem_addr"}, imem_addr, e_pc);
    check({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, e_v});
    check({tag, " instr"}, if_id_instr, e_i);
    check({tag, " pc_plus4"}, if_id_pc_plus4, e_p);
    check({tag, " fetch_count"}, fetch_count, e_c);
  endtask

  initial begin
    // T1 normal run, T2 stall at 0x0C, T3 ID jumps, T4 EX vs stall+ID, T5 align/wrap, then reach 0x40
    vecs[0]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,          32'h04, 1'b1, rom_word(32'h00), 32'h04, 32'd1);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,          32'h08, 1'b1, rom_word(32'h04), 32'h08, 32'd2);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,          32'h0C, 1'b1, rom_word(32'h08), 32'h0C, 32'd3);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,          32'h0C, 1'b1, rom_word(32'h08), 32'h0C, 32'd3);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,          32'h0C, 1'b1, rom_word(32'h08), 32'h0C, 32'd3);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,          32'h10, 1'b1, rom_word(32'h0C), 32'h10, 32'd4);
    vecs[6]  = mk(1'b0, 1'b1, 32'h0C, 1'b0, 32'h0,          32'h0C, 1'b0, 32'h0,            32'h0,  32'd4);
    vecs[7]  = mk(1'b0, 1'b1, 32'h10, 1'b0, 32'h0,          32'h10, 1'b0, 32'h0,            32'h0,  32'd4);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,          32'h14, 1'b1, rom_word(32'h10), 32'h14, 32'd5);
    vecs[9]  = mk(1'b1, 1'b1, 32'h10, 1'b1, 32'h2C,         32'h2C, 1'b0, 32'h0,            32'h0,  32'd5);
    vecs[10] = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,          32'h30, 1'b1, rom_word(32'h2C), 32'h30, 32'd6);
    vecs[11] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h33,         32'h30, 1'b0, 32'h0,            32'h0,  32'd6);
    vecs[12] = mk(1'b1, 1'b1, 32'h07, 1'b0, 32'h0,          32'h04, 1'b0, 32'h0,            32'h0,  32'd6);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'hFFFF_FFFE,  32'hFFFF_FFFC, 1'b0, 32'h0,     32'h0,  32'd6);
    vecs[14] = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,          32'h00, 1'b1, rom_word(32'hFFFF_FFFC), 32'h00, 32'd7);
    vecs[15] = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,          32'h04, 1'b1, rom_word(32'h00), 32'h04, 32'd8);
    vecs[16] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h3C,         32'h3C, 1'b0, 32'h0,            32'h0,  32'd8);
    vecs[17] = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,          32'h40, 1'b1, rom_word(32'h3C), 32'h40, 32'd9);

    reset_n = 1'b0; stall = 1'b0; id_redirect = 1'b0; id_target = 32'h0;
    ex_redirect = 1'b0; ex_target = 32'h0;

    // T1: reset held for three edges
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      stall       = vecs[i].stall;
      id_redirect = vecs[i].id_r;
      id_target   = vecs[i].id_t;
      ex_redirect = vecs[i].ex_r;
      ex_target   = vecs[i].ex_t;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid,
                vecs[i].e_instr, vecs[i].e_pp4, vecs[i].e_cnt);
      @(negedge clk);
    end
    stall = 1'b0; id_redirect = 1'b0; ex_redirect = 1'b0;

    // T6: async reset between edges at pc=0x40 must clear state before the next edge
    #1;
    reset_n = 1'b0;
    #1;
    check_all("async_reset", 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset", 32'h04, 1'b1, rom_word(32'h00), 32'h04, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
